predecode_intr: RTL and testbench

//  Predecode/interrupt front-end that sits directly upstream of the opcode->control FSM.
//  - Latches the fetched opcode byte when the FSM signals a T1 fetch.
//  - Latches and prioritises RST, NMI and IRQ.
//  - When an interrupt is due, substitutes the BRK opcode and presents a one-hot

---
 rtl/predecode_intr_pkg.sv | 45 ++++
 rtl/predecode_intr_if.sv | 27 ++
 rtl/predecode_intr_sync_edge.sv | 32 +++
 rtl/predecode_intr.sv | 92 +++++++++
 tb/tb_predecode_intr.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/predecode_intr_pkg.sv
// Shared types and constants for the predecode/interrupt front-end.
package predecode_intr_pkg;

  localparam int unsigned OPC_W  = 8;
  localparam int unsigned KIND_W = 4;

  // Bit positions in the one-hot interrupt-kind vector
  localparam int unsigned RST_I = 0;
  localparam int unsigned NMI_I = 1;
  localparam int unsigned IRQ_I = 2;
  localparam int unsigned BRK_I = 3;

  localparam logic [OPC_W-1:0] BRK_OPCODE_DEF = 8'h00;

  // Kind of sequence the FSM is currently running
  typedef enum logic [2:0] {
    SVC_NONE = 3'd0,
    SVC_RST  = 3'd1,
    SVC_NMI  = 3'd2,
    SVC_IRQ  = 3'd3,
    SVC_BRK  = 3'd4
  } svc_e;

  // Instruction-register payload presented to the FSM
  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [KIND_W-1:0] kind;
    logic              forced;
  } ir_t;

  // One-hot kind vector for a service state
  function automatic logic [KIND_W-1:0] svc_onehot(svc_e s);
    logic [KIND_W-1:0] v;
    v = '0;
    case (s)
      SVC_RST: v[RST_I] = 1'b1;
      SVC_NMI: v[NMI_I] = 1'b1;
      SVC_IRQ: v[IRQ_I] = 1'b1;
      SVC_BRK: v[BRK_I] = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/predecode_intr_if.sv
// Handshake/bus between the control FSM side and the predecode front-end.
interface predecode_intr_if;
  import predecode_intr_pkg::*;

  logic              RDY;
  logic              T1now;
  logic [OPC_W-1:0]  dataIn;
  logic              statusI;
  logic              nmi;
  logic              irq;
  logic              intAck;
  logic [OPC_W-1:0]  opcodeOut;
  logic [KIND_W-1:0] interruptArray;
  logic              intPending;
  logic              forcedBrk;

  modport master (
    output RDY, T1now, dataIn, statusI, nmi, irq, intAck,
    input  opcodeOut, interruptArray, intPending, forcedBrk
  );

  modport slave (
    input  RDY, T1now, dataIn, statusI, nmi, irq, intAck,
    output opcodeOut, interruptArray, intPending, forcedBrk
  );

endinterface

// File: rtl/predecode_intr_sync_edge.sv
// Multi-flop synchroniser producing a synced level and its rising-edge pulse.
module predecode_intr_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_c_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the async input through the chain and keep the previous synced value
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q[0] <= d_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o  = sync_q[SYNC_STAGES-1];
  assign rise_c_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/predecode_intr.sv
// Predecode/interrupt front-end: latches the opcode at T1 and substitutes BRK
// with a one-hot kind vector whenever RST, NMI or an unmasked IRQ is due.
module predecode_intr
  import predecode_intr_pkg::*;
#(
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [OPC_W-1:0] BRK_OPCODE  = BRK_OPCODE_DEF
) (
  input  logic              phi1,
  input  logic              rst,
  predecode_intr_if.slave   bus
);

  logic nmi_rise;
  logic nmi_level_unused;
  logic irq_level;
  logic irq_rise_unused;

  logic rst_pend_q, rst_pend_d;
  logic nmi_latch_q, nmi_latch_d;
  svc_e svc_q, svc_d;
  ir_t  ir_q, ir_d;

  logic load, ack, irq_pend, rst_post, nmi_post, is_intr;
  svc_e kind;

  predecode_intr_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_nmi_sync (
    .clk_i    (phi1),
    .rst_ni   (rst),
    .d_i      (bus.nmi),
    .level_o  (nmi_level_unused),
    .rise_c_o (nmi_rise)
  );

  predecode_intr_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_irq_sync (
    .clk_i    (phi1),
    .rst_ni   (rst),
    .d_i      (bus.irq),
    .level_o  (irq_level),
    .rise_c_o (irq_rise_unused)
  );

  // Next-state: acknowledge clears first, then the load decision sees post-clear terms
  always_comb begin
    load     = bus.RDY & bus.T1now;
    ack      = bus.RDY & bus.intAck;
    irq_pend = irq_level & ~bus.statusI;
    rst_post = rst_pend_q  & ~(ack && (svc_q == SVC_RST));
    nmi_post = nmi_latch_q & ~(ack && (svc_q == SVC_NMI));

    if (rst_post)                       kind = SVC_RST;
    else if (nmi_post)                  kind = SVC_NMI;
    else if (irq_pend)                  kind = SVC_IRQ;
    else if (bus.dataIn == BRK_OPCODE)  kind = SVC_BRK;
    else                                kind = SVC_NONE;
    is_intr = rst_post | nmi_post | irq_pend;

    rst_pend_d  = rst_post;
    nmi_latch_d = nmi_post | nmi_rise;

    svc_d = svc_q;
    ir_d  = ir_q;
    if (ack) svc_d = SVC_NONE;
    if (load) begin
      svc_d     = kind;
      ir_d.opcode = is_intr ? BRK_OPCODE : bus.dataIn;
      ir_d.kind   = svc_onehot(kind);
      ir_d.forced = is_intr;
    end
  end

  // State registers; reset looks like a pending RST already loaded into the IR
  always_ff @(posedge phi1 or negedge rst) begin
    if (!rst) begin
      rst_pend_q  <= 1'b1;
      nmi_latch_q <= 1'b0;
      svc_q       <= SVC_RST;
      ir_q        <= '{opcode: BRK_OPCODE, kind: svc_onehot(SVC_RST), forced: 1'b1};
    end else begin
      rst_pend_q  <= rst_pend_d;
      nmi_latch_q <= nmi_latch_d;
      svc_q       <= svc_d;
      ir_q        <= ir_d;
    end
  end

  assign bus.opcodeOut      = ir_q.opcode;
  assign bus.interruptArray = ir_q.kind;
  assign bus.forcedBrk      = ir_q.forced;
  assign bus.intPending     = rst_pend_q | nmi_latch_q | irq_pend;

endmodule

// File: tb/tb_predecode_intr.sv
// Directed bench for predecode_intr (SYNC_STAGES=2, BRK opcode 8'h00).
module tb_predecode_intr;

  logic phi1;
  logic rst;
  int   n_checks;
  int   n_fail;

  predecode_intr_if bus ();

  predecode_intr #(.SYNC_STAGES(2), .BRK_OPCODE(8'h00)) dut (
    .phi1 (phi1),
    .rst  (rst),
    .bus  (bus)
  );

  initial phi1 = 1'b0;
  always #5 phi1 = ~phi1;

  // Advance n rising edges, landing 1 time unit after the last one
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge phi1);
      #1;
    end
  endtask

  // One-cycle fetch with T1now; outputs are valid on return
  task automatic do_load(input logic [7:0] d);
    bus.dataIn = d;
    bus.T1now  = 1'b1;
    tick(1);
    bus.T1now  = 1'b0;
  endtask

  task automatic do_ack();
    bus.intAck = 1'b1;
    tick(1);
    bus.intAck = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.RDY = 1'b1; bus.T1now = 1'b0; bus.dataIn = 8'h00; bus.statusI = 1'b1;
    bus.nmi = 1'b0; bus.irq = 1'b0; bus.intAck = 1'b0;
    tick(3);
    n_checks++;
    if (bus.opcodeOut !== 8'h00) begin n_fail++; $display("FAIL reset_opc got=%h exp=00", bus.opcodeOut); end
    n_checks++;
    if (bus.interruptArray !== 4'b0001) begin n_fail++; $display("FAIL reset_kind got=%b exp=0001", bus.interruptArray); end
    n_checks++;
    if (bus.forcedBrk !== 1'b1) begin n_fail++; $display("FAIL reset_forced got=%b exp=1", bus.forcedBrk); end
    rst = 1'b1;
    tick(1);
    n_checks++;
    if (bus.intPending !== 1'b1) begin n_fail++; $display("FAIL reset_pending got=%b exp=1", bus.intPending); end
  endtask

  task automatic test_reset_service();
    do_load(8'hA9);
    n_checks++;
    if (bus.opcodeOut !== 8'h00 || bus.interruptArray !== 4'b0001) begin
      n_fail++; $display("FAIL rst_svc got=%h/%b exp=00/0001", bus.opcodeOut, bus.interruptArray);
    end
    do_ack();
    n_checks++;
    if (bus.intPending !== 1'b0) begin n_fail++; $display("FAIL rst_ack_pending got=%b exp=0", bus.intPending); end
    do_load(8'hA9);
    n_checks++;
    if (bus.opcodeOut !== 8'hA9 || bus.interruptArray !== 4'b0000 || bus.forcedBrk !== 1'b0) begin
      n_fail++; $display("FAIL fetch_a9 got=%h/%b/%b exp=a9/0000/0", bus.opcodeOut, bus.interruptArray, bus.forcedBrk);
    end
  endtask

  task automatic test_brk_fetch();
    do_load(8'h00);
    n_checks++;
    if (bus.opcodeOut !== 8'h00 || bus.interruptArray !== 4'b1000 || bus.forcedBrk !== 1'b0) begin
      n_fail++; $display("FAIL brk_fetch got=%h/%b/%b exp=00/1000/0", bus.opcodeOut, bus.interruptArray, bus.forcedBrk);
    end
    do_ack();
  endtask

  task automatic test_irq_mask();
    bus.irq = 1'b1; bus.statusI = 1'b1;
    tick(10);
    n_checks++;
    if (bus.intPending !== 1'b0) begin n_fail++; $display("FAIL irq_masked_pending got=%b exp=0", bus.intPending); end
    do_load(8'h5A);
    n_checks++;
    if (bus.opcodeOut !== 8'h5A || bus.forcedBrk !== 1'b0) begin
      n_fail++; $display("FAIL irq_masked_fetch got=%h/%b exp=5a/0", bus.opcodeOut, bus.forcedBrk);
    end
    bus.statusI = 1'b0;
    #1;
    n_checks++;
    if (bus.intPending !== 1'b1) begin n_fail++; $display("FAIL irq_unmask_pending got=%b exp=1", bus.intPending); end
    do_load(8'h5A);
    n_checks++;
    if (bus.opcodeOut !== 8'h00 || bus.interruptArray !== 4'b0100 || bus.forcedBrk !== 1'b1) begin
      n_fail++; $display("FAIL irq_take got=%h/%b/%b exp=00/0100/1", bus.opcodeOut, bus.interruptArray, bus.forcedBrk);
    end
    do_ack();
  endtask

  task automatic test_nmi_over_irq();
    bus.nmi = 1'b1;
    tick(3);
    do_load(8'h11);
    n_checks++;
    if (bus.interruptArray !== 4'b0010) begin n_fail++; $display("FAIL nmi_prio got=%b exp=0010", bus.interruptArray); end
    bus.nmi = 1'b0;
    do_ack();
    do_load(8'h11);
    n_checks++;
    if (bus.interruptArray !== 4'b0100) begin n_fail++; $display("FAIL irq_after_nmi got=%b exp=0100", bus.interruptArray); end
    do_ack();
    // IRQ dropped before the next load: level is not remembered
    bus.irq = 1'b0;
    tick(3);
    do_load(8'h22);
    n_checks++;
    if (bus.opcodeOut !== 8'h22 || bus.forcedBrk !== 1'b0) begin
      n_fail++; $display("FAIL irq_dropped got=%h/%b exp=22/0", bus.opcodeOut, bus.forcedBrk);
    end
    bus.statusI = 1'b1;
  endtask

  task automatic test_nmi_rdy_low();
    do_load(8'h3C);
    bus.RDY = 1'b0; bus.T1now = 1'b1; bus.dataIn = 8'hEE; bus.nmi = 1'b1;
    tick(2);
    n_checks++;
    if (bus.intPending !== 1'b0) begin n_fail++; $display("FAIL nmi_early got=%b exp=0", bus.intPending); end
    tick(1);
    n_checks++;
    if (bus.intPending !== 1'b1) begin n_fail++; $display("FAIL nmi_latency got=%b exp=1", bus.intPending); end
    tick(2);
    n_checks++;
    if (bus.opcodeOut !== 8'h3C || bus.forcedBrk !== 1'b0 || bus.interruptArray !== 4'b0000) begin
      n_fail++; $display("FAIL rdy_hold got=%h/%b/%b exp=3c/0000/0", bus.opcodeOut, bus.interruptArray, bus.forcedBrk);
    end
    bus.RDY = 1'b1;
    tick(1);
    bus.T1now = 1'b0;
    n_checks++;
    if (bus.opcodeOut !== 8'h00 || bus.interruptArray !== 4'b0010 || bus.forcedBrk !== 1'b1) begin
      n_fail++; $display("FAIL nmi_rdy_take got=%h/%b/%b exp=00/0010/1", bus.opcodeOut, bus.interruptArray, bus.forcedBrk);
    end
    do_ack();
    tick(2);
    n_checks++;
    if (bus.intPending !== 1'b0) begin n_fail++; $display("FAIL nmi_held_once got=%b exp=0", bus.intPending); end
    bus.nmi = 1'b0;
  endtask

  task automatic test_nmi_ack_collision();
    bus.nmi = 1'b1;
    tick(3);
    do_load(8'h44);
    bus.nmi = 1'b0;
    tick(3);
    bus.nmi = 1'b1;
    tick(2);
    do_ack();
    n_checks++;
    if (bus.intPending !== 1'b1) begin n_fail++; $display("FAIL nmi_collide_pending got=%b exp=1", bus.intPending); end
    do_load(8'h44);
    n_checks++;
    if (bus.interruptArray !== 4'b0010 || bus.forcedBrk !== 1'b1) begin
      n_fail++; $display("FAIL nmi_second got=%b/%b exp=0010/1", bus.interruptArray, bus.forcedBrk);
    end
    do_ack();
    n_checks++;
    if (bus.intPending !== 1'b0) begin n_fail++; $display("FAIL nmi_second_clear got=%b exp=0", bus.intPending); end
    bus.nmi = 1'b0;
    tick(3);
  endtask

  task automatic test_async_reset();
    do_load(8'h42);
    bus.nmi = 1'b1;
    tick(3);
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.opcodeOut !== 8'h00 || bus.interruptArray !== 4'b0001 || bus.forcedBrk !== 1'b1) begin
      n_fail++; $display("FAIL async_rst got=%h/%b/%b exp=00/0001/1", bus.opcodeOut, bus.interruptArray, bus.forcedBrk);
    end
    bus.nmi = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
    do_load(8'h66);
    // intAck and load together: RST cleared first, NMI latch was lost in reset
    bus.intAck = 1'b1;
    do_load(8'h77);
    bus.intAck = 1'b0;
    n_checks++;
    if (bus.opcodeOut !== 8'h77 || bus.interruptArray !== 4'b0000 || bus.forcedBrk !== 1'b0) begin
      n_fail++; $display("FAIL ack_load got=%h/%b/%b exp=77/0000/0", bus.opcodeOut, bus.interruptArray, bus.forcedBrk);
    end
    n_checks++;
    if (bus.intPending !== 1'b0) begin n_fail++; $display("FAIL nmi_lost got=%b exp=0", bus.intPending); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_reset_service();
    test_brk_fetch();
    test_irq_mask();
    test_nmi_over_irq();
    test_nmi_rdy_low();
    test_nmi_ack_collision();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
